ycbcr_rgb_stream: RTL and testbench
===================================

YCBCR_RGB_STREAM -- requirements
Module: ycbcr_rgb_stream

Interface
REQ-001 SHALL have parameter DW, default 8, input sample width (4..12).
REQ-002 SHALL have parameter FRAC, default 8, coefficient fractional bits (4..16).
REQ-003 SHALL have parameter OW, default 16, output width (≥ DW).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous abort of partial pixel and output.
REQ-007 SHALL have port clip_en  input  1  1 = rounded, clamped 0..2^DW-1; 0 = raw fixed-point.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port in_data  input  DW  component byte, order Y, Cb, Cr per pixel.
REQ-011 SHALL have port out_valid  output  1  R/G/B hold a completed pixel.
REQ-012 SHALL have port out_ready  input  1  consumer takes pixel.
REQ-013 SHALL have ports R, G, B  output  OW each  converted components.
REQ-014 SHALL have port phase  output  2  current FSM state, for debug.

Function
REQ-015 SHALL accept a component only on a cycle with in_valid && in_ready (transfer).
REQ-016 SHALL run FSM S_Y(0) -> S_CB(1) -> S_CR(2) -> S_Y, advancing only on transfer.
REQ-017 SHALL, on Y transfer, load accR = accG = accB = Y<<FRAC and latch clip_en for the pixel.
REQ-018 SHALL, on Cb transfer, with c = Cb - 2^(DW-1), add -K_CB_G*c to accG and +K_CB_B*c to accB.
REQ-019 SHALL, on Cr transfer, with c = Cr - 2^(DW-1), add +K_CR_R*c to accR and -K_CR_G*c to accG, then load the output register.
REQ-020 SHALL use signed accumulators of DW+FRAC+4 bits; no internal overflow for any input.
REQ-021 SHALL, at FRAC=8, use coefficients 351, 179, 86, 443 (CR_R, CR_G, CB_G, CB_B).
REQ-022 SHALL, for clip_en=1, output (acc + 2^(FRAC-1)) >>> FRAC clamped to 0..2^DW-1, zero-extended to OW.
REQ-023 SHALL, for clip_en=0, output acc truncated to low OW bits (two's complement).
REQ-024 SHALL assert out_valid the cycle after the Cr transfer; latency Cr->out_valid = 1 cycle.
REQ-025 SHALL hold R/G/B/out_valid stable until out_valid && out_ready.
REQ-026 SHALL drive in_ready = !(phase==S_CR && out_valid && !out_ready); the next pixel's Y and Cb are accepted while output stalls.
REQ-027 SHALL sustain one pixel per 3 cycles with in_valid and out_ready held high.
REQ-028 SHALL, on a cycle where a pixel is drained and a new Cr is transferred, load the new pixel with out_valid staying 1.
REQ-029 SHALL, on clear, return to S_Y, zero accumulators, and drop out_valid; clear wins over a simultaneous transfer, and the byte is discarded.

Reset
REQ-030 SHALL, on reset, set phase=S_Y, accumulators=0, R=G=B=0, out_valid=0, latched clip_en=0.
REQ-031 SHALL, on reset mid-pixel, discard the partial pixel; the first transfer after reset is a Y.
REQ-032 SHALL drive in_ready=1 while reset is asserted and after it.

Structure
REQ-033 SHALL place the state encoding and the Q16 coefficient constants in shared package ycbcr_pkg: 89856, 45824, 22016, 113408.
REQ-034 SHALL derive each coefficient as (K16 + 2^(15-FRAC)) >> (16-FRAC); for FRAC=16 this is K16 itself.
REQ-035 SHALL place round/clamp/truncate in sub-module ycbcr_out_fmt, instantiated once per channel.

Verification
REQ-036 SHALL cover: defaults, clip_en=0, Y/Cb/Cr=128/128/128 -> R=G=B=0x8000, out_valid 1 cycle after Cr.
REQ-037 SHALL cover: clip_en=1, 255/128/255 -> R=255, G=166, B=255; clip_en=0 same -> R=44321, G=42547, B=65280.
REQ-038 SHALL cover: clip_en=1, 0/0/0 -> R=0, G=133, B=0.
REQ-039 SHALL cover: out_ready=0 for 10 cycles over 3 pixels -> in_ready low only in S_CR, no pixel lost or reordered, outputs stable.
REQ-040 SHALL cover: clear with in_valid during S_CB -> byte discarded, phase=0, out_valid=0; the next 3 bytes form a correct pixel.
REQ-041 SHALL cover: reset asserted mid-pixel and with output stalled -> all outputs 0; the next pixel converts correctly.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared definitions for the streaming YCbCr -> RGB converter.
//   phase_t  : per-pixel component phase (Y, Cb, Cr), also exported on the
//              debug port.
//   K16_*    : conversion coefficients in Q16 fixed point.
//   coef_q() : rescales a Q16 coefficient to FRAC fractional bits with
//              round-half-up. At FRAC=16 the Q16 value is used as-is.
package ycbcr_pkg;

    typedef enum logic [1:0] {
        S_Y  = 2'd0,
        S_CB = 2'd1,
        S_CR = 2'd2
    } phase_t;

    localparam int unsigned K16_CR_R = 32'd89856;
    localparam int unsigned K16_CR_G = 32'd45824;
    localparam int unsigned K16_CB_G = 32'd22016;
    localparam int unsigned K16_CB_B = 32'd113408;

    function automatic int unsigned coef_q(input int unsigned k16, input int unsigned frac);
        int unsigned res;
        if (frac >= 32'd16) begin
            res = k16;
        end else begin
            res = (k16 + (32'd1 << (32'd15 - frac))) >> (32'd16 - frac);
        end
        return res;
    endfunction

endpackage

// File: rtl/ycbcr_out_fmt.sv
// Output formatter for one colour channel.
//   acc     : signed fixed-point accumulator (FRAC fractional bits)
//   clip_en : 1 = round to nearest, clamp to 0..2^DW-1, zero-extend to OW
//             0 = raw two's-complement accumulator truncated to OW bits
//   val     : formatted channel value
module ycbcr_out_fmt
    import ycbcr_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8,
    parameter int OW   = 16,
    parameter int AW   = DW + FRAC + 4
) (
    input  logic signed [AW-1:0] acc,
    input  logic                 clip_en,
    output logic [OW-1:0]        val
);

    localparam logic signed [AW-1:0] ROUND = AW'(2 ** (FRAC - 1));
    localparam logic signed [AW-1:0] MAXV  = AW'(2 ** DW - 1);

    logic signed [AW-1:0] rnd_s;
    logic [DW-1:0]        clamp_s;

    // Round, clamp and select between clamped and raw representations.
    always_comb begin
        rnd_s = (acc + ROUND) >>> FRAC;
        if (rnd_s[AW-1]) begin
            clamp_s = {DW{1'b0}};
        end else if (rnd_s > MAXV) begin
            clamp_s = {DW{1'b1}};
        end else begin
            clamp_s = rnd_s[DW-1:0];
        end

        // A size cast of the signed accumulator sign-extends or truncates
        // as needed, giving the raw two's-complement view.
        if (clip_en) begin
            val = OW'(clamp_s);
        end else begin
            val = OW'(acc);
        end
    end

endmodule

// File: rtl/ycbcr_rgb_stream.sv
// Streaming YCbCr -> RGB converter. Components arrive one per transfer in
// the order Y, Cb, Cr; the finished pixel appears on R/G/B one cycle after
// the Cr transfer and is held until the consumer takes it.
//   clk, reset        : clock, asynchronous active-high reset
//   clear             : synchronous abort of partial pixel and pending output
//   clip_en           : format select, latched with each pixel's Y
//   in_valid/in_ready : component handshake, in_data is the component
//   out_valid/out_ready : pixel handshake, R/G/B the converted channels
//   phase             : current component phase (debug)
module ycbcr_rgb_stream
    import ycbcr_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8,
    parameter int OW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          clip_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] R,
    output logic [OW-1:0] G,
    output logic [OW-1:0] B,
    output logic [1:0]    phase
);

    localparam int AW = DW + FRAC + 4;

    localparam logic signed [AW-1:0] KC_CR_R = AW'(coef_q(K16_CR_R, FRAC));
    localparam logic signed [AW-1:0] KC_CR_G = AW'(coef_q(K16_CR_G, FRAC));
    localparam logic signed [AW-1:0] KC_CB_G = AW'(coef_q(K16_CB_G, FRAC));
    localparam logic signed [AW-1:0] KC_CB_B = AW'(coef_q(K16_CB_B, FRAC));
    localparam logic signed [AW-1:0] HALF    = AW'(2 ** (DW - 1));

    phase_t               state_r;
    phase_t               state_nxt_s;
    logic signed [AW-1:0] acc_red_r;
    logic signed [AW-1:0] acc_grn_r;
    logic signed [AW-1:0] acc_blu_r;
    logic                 clip_r;
    logic                 out_valid_r;
    logic [OW-1:0]        red_r;
    logic [OW-1:0]        grn_r;
    logic [OW-1:0]        blu_r;

    logic                 in_ready_s;
    logic                 xfer_s;
    logic signed [AW-1:0] c_s;
    logic signed [AW-1:0] fin_red_s;
    logic signed [AW-1:0] fin_grn_s;
    logic [OW-1:0]        fmt_red_s;
    logic [OW-1:0]        fmt_grn_s;
    logic [OW-1:0]        fmt_blu_s;

    // Only a Cr that would overwrite a still-unconsumed pixel is held off;
    // Y and Cb of the next pixel go into the accumulators meanwhile.
    assign in_ready_s = !((state_r == S_CR) && out_valid_r && !out_ready);
    assign xfer_s     = in_valid && in_ready_s;

    // Chroma offset removal and the final (post-Cr) red/green sums that feed
    // the output formatters directly, so the pixel registers on the Cr edge.
    always_comb begin
        c_s       = $signed(AW'(in_data)) - HALF;
        fin_red_s = acc_red_r + KC_CR_R * c_s;
        fin_grn_s = acc_grn_r - KC_CR_G * c_s;
    end

    ycbcr_out_fmt #(.DW(DW), .FRAC(FRAC), .OW(OW), .AW(AW)) u_fmt_red (
        .acc(fin_red_s), .clip_en(clip_r), .val(fmt_red_s)
    );
    ycbcr_out_fmt #(.DW(DW), .FRAC(FRAC), .OW(OW), .AW(AW)) u_fmt_grn (
        .acc(fin_grn_s), .clip_en(clip_r), .val(fmt_grn_s)
    );
    ycbcr_out_fmt #(.DW(DW), .FRAC(FRAC), .OW(OW), .AW(AW)) u_fmt_blu (
        .acc(acc_blu_r), .clip_en(clip_r), .val(fmt_blu_s)
    );

    // Phase next-state: advance on transfer, clear always returns to Y.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = S_Y;
        end else if (xfer_s) begin
            case (state_r)
                S_Y:     state_nxt_s = S_CB;
                S_CB:    state_nxt_s = S_CR;
                S_CR:    state_nxt_s = S_Y;
                default: state_nxt_s = S_Y;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_Y;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-pixel accumulators and the clip mode captured with Y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_red_r <= '0;
            acc_grn_r <= '0;
            acc_blu_r <= '0;
            clip_r    <= 1'b0;
        end else if (clear) begin
            acc_red_r <= '0;
            acc_grn_r <= '0;
            acc_blu_r <= '0;
        end else if (xfer_s) begin
            case (state_r)
                S_Y: begin
                    acc_red_r <= $signed(AW'(in_data) << FRAC);
                    acc_grn_r <= $signed(AW'(in_data) << FRAC);
                    acc_blu_r <= $signed(AW'(in_data) << FRAC);
                    clip_r    <= clip_en;
                end
                S_CB: begin
                    acc_grn_r <= acc_grn_r - KC_CB_G * c_s;
                    acc_blu_r <= acc_blu_r + KC_CB_B * c_s;
                end
                S_CR: begin
                    acc_red_r <= fin_red_s;
                    acc_grn_r <= fin_grn_s;
                end
                default: begin
                    acc_red_r <= acc_red_r;
                end
            endcase
        end
    end

    // Output pixel register: load on Cr transfer (even while draining the
    // previous pixel), otherwise hold until the consumer accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            red_r       <= '0;
            grn_r       <= '0;
            blu_r       <= '0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
            red_r       <= '0;
            grn_r       <= '0;
            blu_r       <= '0;
        end else if (xfer_s && (state_r == S_CR)) begin
            out_valid_r <= 1'b1;
            red_r       <= fmt_red_s;
            grn_r       <= fmt_grn_s;
            blu_r       <= fmt_blu_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign R         = red_r;
    assign G         = grn_r;
    assign B         = blu_r;
    assign phase     = state_r;

endmodule

// File: tb/tb_ycbcr_rgb_stream.sv
// Self-checking bench for ycbcr_rgb_stream at default parameters.
module tb_ycbcr_rgb_stream;

    logic        clk = 1'b0;
    logic        reset, clear, clip_en, in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [7:0]  in_data;
    logic [15:0] R, G, B;
    logic [1:0]  phase;

    ycbcr_rgb_stream dut (
        .clk(clk), .reset(reset), .clear(clear), .clip_en(clip_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .G(G), .B(B), .phase(phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: expected pending pixel(s) and component position.
    logic [47:0] exp_q[$];
    int          m_phase = 0;
    int          m_y = 0;
    int          m_cb = 0;
    logic        m_clip = 1'b0;

    task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_chan(input int a, input logic clip);
        int v;
        logic [31:0] t;
        if (clip) begin
            v = (a + 128) >>> 8;
            if (v < 0) v = 0;
            else if (v > 255) v = 255;
            return 16'(v);
        end
        t = a;
        return t[15:0];
    endfunction

    // BT.601-style conversion with the 8-fraction-bit coefficients.
    function automatic logic [47:0] ref_pixel(input int y, input int cb, input int cr, input logic clip);
        int cbc, crc;
        cbc = cb - 128;
        crc = cr - 128;
        return {ref_chan(y * 256 + 351 * crc, clip),
                ref_chan(y * 256 - 86 * cbc - 179 * crc, clip),
                ref_chan(y * 256 + 443 * cbc, clip)};
    endfunction

    // One clock cycle: drive inputs at the falling edge, check, update model.
    task automatic step(input logic iv, input logic [7:0] d, input logic clr,
                        input logic ordy, input logic clip, output logic took);
        logic exp_ov, exp_rdy;
        in_valid = iv; in_data = d; clear = clr; out_ready = ordy; clip_en = clip;
        #1;
        exp_ov  = (exp_q.size() > 0);
        exp_rdy = !(m_phase == 2 && exp_ov && !ordy);
        check_val("phase", 48'(phase), 48'(m_phase));
        check_val("out_valid", 48'(out_valid), 48'(exp_ov));
        check_val("in_ready", 48'(in_ready), 48'(exp_rdy));
        if (exp_ov) begin
            check_val("rgb", {R, G, B}, exp_q[0]);
            if (ordy) void'(exp_q.pop_front());
        end
        took = iv && exp_rdy && !clr;
        if (clr) begin
            m_phase = 0;
            exp_q.delete();
        end else if (took) begin
            case (m_phase)
                0: begin m_y = int'(d); m_clip = clip; m_phase = 1; end
                1: begin m_cb = int'(d); m_phase = 2; end
                default: begin
                    exp_q.push_back(ref_pixel(m_y, m_cb, int'(d), m_clip));
                    m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic clip, input logic ordy);
        logic took;
        took = 1'b0;
        for (int i = 0; i < 50 && !took; i++) step(1'b1, d, 1'b0, ordy, clip, took);
        if (!took) check_val("send_timeout", 48'd0, 48'd1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, took);
    endtask

    task automatic pixel_expect(input string tag, input int y, input int cb, input int cr,
                                input logic clip, input logic [47:0] exp);
        send(8'(y), clip, 1'b1);
        send(8'(cb), clip, 1'b1);
        send(8'(cr), clip, 1'b1);
        check_val({tag, "_valid"}, 48'(out_valid), 48'd1);
        check_val(tag, {R, G, B}, exp);
        idle(1);
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        in_valid = 1'b1;
        #1;
        check_val({tag, "_rgb"}, {R, G, B}, 48'd0);
        check_val({tag, "_ov"}, 48'(out_valid), 48'd0);
        check_val({tag, "_rdy"}, 48'(in_ready), 48'd1);
        check_val({tag, "_phase"}, 48'(phase), 48'd0);
        m_phase = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic took;
        logic [7:0] bytes [9];
        int k;
        reset = 1'b1; clear = 1'b0; clip_en = 1'b0; in_valid = 1'b0;
        in_data = 8'd0; out_ready = 1'b1;
        @(negedge clk);
        reset_check("reset");

        // Directed conversions.
        pixel_expect("grey_raw", 128, 128, 128, 1'b0, {16'h8000, 16'h8000, 16'h8000});
        pixel_expect("white_clip", 255, 128, 255, 1'b1, {16'd255, 16'd166, 16'd255});
        pixel_expect("white_raw", 255, 128, 255, 1'b0, {16'd44321, 16'd42547, 16'd65280});
        pixel_expect("black_clip", 0, 0, 0, 1'b1, {16'd0, 16'd133, 16'd0});

        // Backpressure: consumer stalled for 10 cycles across 3 pixels.
        for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
        k = 0;
        for (int c = 0; c < 80 && (k < 9 || exp_q.size() > 0); c++) begin
            step(k < 9, (k < 9) ? bytes[k] : 8'd0, 1'b0, c >= 10, 1'b1, took);
            if (took) k++;
        end
        check_val("stall_all_sent", 48'(k), 48'd9);
        check_val("stall_drained", 48'(out_valid), 48'd0);

        // Clear during Cb with a stalled pixel pending.
        send(8'd10, 1'b1, 1'b0); send(8'd20, 1'b1, 1'b0); send(8'd30, 1'b1, 1'b0);
        send(8'd200, 1'b1, 1'b0);
        step(1'b1, 8'd77, 1'b1, 1'b0, 1'b1, took);
        check_val("clear_phase", 48'(phase), 48'd0);
        check_val("clear_ov", 48'(out_valid), 48'd0);
        pixel_expect("after_clear", 128, 128, 128, 1'b0, {16'h8000, 16'h8000, 16'h8000});

        // Reset mid-pixel with output stalled.
        send(8'd50, 1'b0, 1'b0); send(8'd60, 1'b0, 1'b0); send(8'd70, 1'b0, 1'b0);
        send(8'd90, 1'b0, 1'b0); send(8'd100, 1'b0, 1'b0);
        reset_check("midreset");
        pixel_expect("after_reset", 255, 128, 255, 1'b1, {16'd255, 16'd166, 16'd255});

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), took);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
